// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling state machine feeding a small FIFO with a valid/ready pop side.
// Framing and overrun problems are latched in sticky flags until err_clr.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 57600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          push_req, push, pop, full, ferr_set, ovr_set;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bitidx_q    <= '0;
      shreg_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitidx_q    <= bitidx_d;
      shreg_q     <= shreg_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= shreg_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bitidx_d = bitidx_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: if (!rxs) state_d = S_START;
      S_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          state_d  = rxs ? S_IDLE : S_DATA;
          bitidx_d = '0;
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          shreg_d[bitidx_q] = rxs;
          cnt_d             = '0;
          if (bitidx_q == 3'd7) state_d = S_STOP;
          else bitidx_d = bitidx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == CW'(DIV - 1)) begin
          if (rxs) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: if (rxs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop        = rx_valid_q && rx_ready;
    push       = push_req && (!full || pop);
    ovr_set    = push_req && full && !pop;
    wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
    rx_valid_d = (wptr_d != rptr_d);
    rx_data_d  = (push && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) ? shreg_q : mem_q[rptr_d[AW-1:0]];
    frame_err_d = ferr_set | (frame_err_q & ~err_clr);
    overrun_d   = ovr_set | (overrun_q & ~err_clr);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: bytes are queued as they are serialised and popped as the DUT presents them.
// A faster baud is used so that every frame stays short in cycles.
module tb_uart_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;
  localparam int DEPTH    = 4;
  localparam int PUSH_LAT = 2 + HALF + 9 * DIV;

  logic       clk = 1'b0;
  logic       rst, rxd, rxReady, errClr;
  logic [7:0] rxData;
  logic       rxValid, frameErr, overrun;

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] expQ[$];

  always #10 clk = ~clk;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .rx_data(rxData), .rx_valid(rxValid), .rx_ready(rxReady),
    .frame_err(frameErr), .overrun(overrun), .err_clr(errClr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Serialises one frame starting at a negedge; stopLowBits holds the stop bit low that many bit times first.
  task automatic applyStimulus(input logic [7:0] data, input int stopLowBits = 0, input bit expectPush = 1'b1);
    if (expectPush) expQ.push_back(data);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (DIV) @(negedge clk);
    end
    if (stopLowBits > 0) begin
      rxd = 1'b0;
      repeat (stopLowBits * DIV) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic popCheck(input string tag);
    int n = 0;
    while (!rxValid && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, rxValid, 1);
    if (rxValid) begin
      checkOutput({tag, "_pending"}, 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) checkOutput({tag, "_data"}, rxData, expQ.pop_front());
      rxReady = 1'b1;
      @(negedge clk);
      rxReady = 1'b0;
    end
  endtask

  task automatic pulseErrClr();
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
  endtask

  initial begin
    #(20 * 40000);
    $display("[TB] FAIL watchdog: run did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1; rxd = 1'b1; rxReady = 1'b0; errClr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", rxValid, 0);
    checkOutput("rst_data", rxData, 0);
    checkOutput("rst_ferr", frameErr, 0);
    checkOutput("rst_ovr", overrun, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single byte with start-to-valid latency measurement
    lat = -1;
    fork
      applyStimulus(8'hC3);
      for (int i = 1; i <= PUSH_LAT + DIV; i++) begin
        @(negedge clk);
        if (rxValid && lat < 0) lat = i;
      end
    join
    checkOutput("t1_latency", 32'(lat), 32'(PUSH_LAT + 1));
    checkOutput("t1_ferr", frameErr, 0);
    checkOutput("t1_ovr", overrun, 0);
    popCheck("t1");
    checkOutput("t1_empty", rxValid, 0);

    // back-to-back fill, then one extra byte overruns
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h55);
    applyStimulus(8'hAA);
    applyStimulus(8'h12, 0, 1'b0);
    checkOutput("t2_overrun", overrun, 1);
    checkOutput("t2_ferr", frameErr, 0);
    for (int i = 0; i < 4; i++) popCheck("t2");
    checkOutput("t2_empty", rxValid, 0);
    pulseErrClr();
    checkOutput("t2_ovr_clr", overrun, 0);

    // stop bit held low, then a clean frame
    applyStimulus(8'hA5, 3, 1'b0);
    checkOutput("t3_ferr", frameErr, 1);
    checkOutput("t3_nopush", rxValid, 0);
    applyStimulus(8'h3C);
    popCheck("t3");
    checkOutput("t3_sticky", frameErr, 1);
    pulseErrClr();
    checkOutput("t3_ferr_clr", frameErr, 0);

    // short glitch must be rejected as a false start
    rxd = 1'b0;
    repeat (DIV * 3 / 10) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    checkOutput("t4_valid", rxValid, 0);
    checkOutput("t4_ferr", frameErr, 0);
    checkOutput("t4_ovr", overrun, 0);
    applyStimulus(8'h5A);
    popCheck("t4");

    // full FIFO, pop coincides with the stop-bit push
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    fork
      applyStimulus(8'h77);
      begin
        repeat (PUSH_LAT) @(negedge clk);
        checkOutput("t5_head", rxData, expQ.pop_front());
        rxReady = 1'b1;
        @(negedge clk);
        rxReady = 1'b0;
      end
    join
    checkOutput("t5_overrun", overrun, 0);
    for (int i = 0; i < 4; i++) popCheck("t5");
    checkOutput("t5_empty", rxValid, 0);

    // reset mid-frame with a stale byte in the FIFO
    applyStimulus(8'h99, 0, 1'b0);
    rxd = 1'b0;
    repeat (5 * DIV + DIV / 2) @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6_rst_valid", rxValid, 0);
    checkOutput("t6_rst_data", rxData, 0);
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    checkOutput("t6_idle_valid", rxValid, 0);
    applyStimulus(8'h81);
    popCheck("t6");
    checkOutput("t6_ferr", frameErr, 0);
    checkOutput("t6_ovr", overrun, 0);
    checkOutput("t6_empty", rxValid, 0);

    checkOutput("sb_drained", 32'(expQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
